// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: FSM states, access sizes and the decoded op.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } lsu_size_e;

    localparam logic [3:0] WSTRB_ALL = 4'b1111;

    typedef struct packed {
        logic      store;
        logic      unsigned_ld;
        lsu_size_e size;
    } lsu_op_t;

    function automatic logic is_misaligned(lsu_size_e size, logic [1:0] off);
        return (size == HALF && off[0]) || (size == WORD && off != 2'b00);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-aligned data-memory bus with byte strobes and a req/ack handshake.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    // The master holds req and every bus field stable until it samples ack=1;
    // read data is valid in the same cycle as ack. One access is outstanding at most.
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store replication/strobes and load extraction with extension.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  lsu_op_t     op_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] load_data_o
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = rdata_i[{off_i, 3'b000} +: 8];
    assign half_lane = rdata_i[{off_i[1], 4'b0000} +: 16];

    always_comb begin
        wdata_o     = '0;
        wstrb_o     = '0;
        load_data_o = '0;
        if (op_i.store) begin
            case (op_i.size)
                BYTE: begin
                    wdata_o = {4{store_data_i[7:0]}};
                    wstrb_o = 4'b0001 << off_i;
                end
                HALF: begin
                    wdata_o = {2{store_data_i[15:0]}};
                    wstrb_o = off_i[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    wdata_o = store_data_i;
                    wstrb_o = WSTRB_ALL;
                end
            endcase
        end else begin
            case (op_i.size)
                BYTE:    load_data_o = {{24{byte_lane[7] & ~op_i.unsigned_ld}}, byte_lane};
                HALF:    load_data_o = {{16{half_lane[15] & ~op_i.unsigned_ld}}, half_lane};
                default: load_data_o = rdata_i;
            endcase
        end
    end
endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage: decodes the op, runs one bus access with timeout,
// and returns extended load data with a one-cycle done pulse.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sb,
    input  logic               sh,
    input  logic               sw,
    input  logic               lb,
    input  logic               lh,
    input  logic               lw,
    input  logic               lbu,
    input  logic               lhu,
    input  logic [ADDR_W-1:0]  address,
    input  logic [31:0]        write_data,
    output logic               stall,
    output logic               done,
    output logic [31:0]        read_data,
    output logic               misaligned,
    output logic               illegal_op,
    output logic               bus_error,
    load_store_unit_if.master  bus,
    output lsu_state_e         dbg_state_o
);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_e        state_q;
    lsu_op_t           op_q;
    logic [1:0]        off_q;
    logic [7:0]        cnt_q;
    logic              done_q, misaligned_q, illegal_q, bus_error_q;
    logic [31:0]       read_data_q;
    logic              mem_req_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [3:0]        mem_wstrb_q;

    logic [7:0]  op_bits;
    lsu_op_t     dec_op;
    lsu_op_t     align_op;
    logic [1:0]  align_off;
    logic [31:0] align_wdata, align_load;
    logic [3:0]  align_wstrb;

    assign op_bits = {sb, sh, sw, lb, lh, lw, lbu, lhu};

    always_comb begin
        dec_op             = '0;
        dec_op.store       = sb | sh | sw;
        dec_op.unsigned_ld = lbu | lhu;
        if (sw | lw)
            dec_op.size = WORD;
        else if (sh | lh | lhu)
            dec_op.size = HALF;
        else
            dec_op.size = BYTE;
    end

    // In IDLE the aligner shapes the incoming store; afterwards it extracts the load.
    assign align_op  = (state_q == IDLE) ? dec_op : op_q;
    assign align_off = (state_q == IDLE) ? address[1:0] : off_q;

    lsu_lane_align u_align (
        .op_i         (align_op),
        .off_i        (align_off),
        .store_data_i (write_data),
        .rdata_i      (bus.mem_rdata),
        .wdata_o      (align_wdata),
        .wstrb_o      (align_wstrb),
        .load_data_o  (align_load)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= '0;
            off_q        <= '0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            illegal_q    <= 1'b0;
            bus_error_q  <= 1'b0;
            read_data_q  <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q       <= 1'b0;
                    misaligned_q <= 1'b0;
                    illegal_q    <= 1'b0;
                    bus_error_q  <= 1'b0;
                    read_data_q  <= '0;
                    if (start) begin
                        if (!$onehot(op_bits)) begin
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            illegal_q <= 1'b1;
                        end else if (is_misaligned(dec_op.size, address[1:0])) begin
                            state_q      <= DONE;
                            done_q       <= 1'b1;
                            misaligned_q <= 1'b1;
                        end else begin
                            state_q     <= REQ;
                            op_q        <= dec_op;
                            off_q       <= address[1:0];
                            cnt_q       <= '0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= dec_op.store;
                            mem_addr_q  <= {address[ADDR_W-1:2], 2'b00};
                            mem_wdata_q <= align_wdata;
                            mem_wstrb_q <= align_wstrb;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_ack || cnt_q == TIMEOUT_LAST) begin
                        state_q     <= DONE;
                        done_q      <= 1'b1;
                        bus_error_q <= !bus.mem_ack;
                        read_data_q <= (bus.mem_ack && !op_q.store) ? align_load : 32'd0;
                        cnt_q       <= '0;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_wdata_q <= '0;
                        mem_wstrb_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    done_q       <= 1'b0;
                    misaligned_q <= 1'b0;
                    illegal_q    <= 1'b0;
                    bus_error_q  <= 1'b0;
                    read_data_q  <= '0;
                end
            endcase
        end
    end

    assign stall       = (state_q == IDLE && start) || state_q == REQ;
    assign done        = done_q;
    assign read_data   = read_data_q;
    assign misaligned  = misaligned_q;
    assign illegal_op  = illegal_q;
    assign bus_error   = bus_error_q;
    assign dbg_state_o = state_q;

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed and random accesses with a result scoreboard.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int W = 35;
    localparam logic [7:0] OP_SB  = 8'h80;
    localparam logic [7:0] OP_SH  = 8'h40;
    localparam logic [7:0] OP_SW  = 8'h20;
    localparam logic [7:0] OP_LB  = 8'h10;
    localparam logic [7:0] OP_LH  = 8'h08;
    localparam logic [7:0] OP_LW  = 8'h04;
    localparam logic [7:0] OP_LBU = 8'h02;
    localparam logic [7:0] OP_LHU = 8'h01;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  op_sel = '0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic        stall, done, misaligned, illegal_op, bus_error;
    logic [31:0] read_data;
    lsu_state_e  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] sb_exp;

    load_store_unit_if #(.ADDR_W(32)) mem_if ();

    load_store_unit #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .sb          (op_sel[7]),
        .sh          (op_sel[6]),
        .sw          (op_sel[5]),
        .lb          (op_sel[4]),
        .lh          (op_sel[3]),
        .lw          (op_sel[2]),
        .lbu         (op_sel[1]),
        .lhu         (op_sel[0]),
        .address     (address),
        .write_data  (write_data),
        .stall       (stall),
        .done        (done),
        .read_data   (read_data),
        .misaligned  (misaligned),
        .illegal_op  (illegal_op),
        .bus_error   (bus_error),
        .bus         (mem_if.master),
        .dbg_state_o (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pack(input bit be, input bit il, input bit mis,
                                          input logic [31:0] rd);
        return {be, il, mis, rd};
    endfunction

    // reference model
    function automatic logic [31:0] model_load(input logic [7:0] op, input logic [1:0] off,
                                               input logic [31:0] rd);
        logic [31:0] s;
        s = rd >> (int'(off) * 8);
        case (op)
            OP_LB:   return {{24{s[7]}}, s[7:0]};
            OP_LBU:  return {24'h0, s[7:0]};
            OP_LH:   return {{16{s[15]}}, s[15:0]};
            OP_LHU:  return {16'h0, s[15:0]};
            OP_LW:   return rd;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] model_wstrb(input logic [7:0] op, input logic [1:0] off);
        case (op)
            OP_SB:   return 4'b0001 << off;
            OP_SH:   return 4'b0011 << off;
            OP_SW:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [7:0] op, input logic [31:0] wd);
        case (op)
            OP_SB:   return {4{wd[7:0]}};
            OP_SH:   return {2{wd[15:0]}};
            OP_SW:   return wd;
            default: return 32'h0;
        endcase
    endfunction

    // scoreboard: every done pulse pops one expected result
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_done", 64'(1), 64'(0));
            end else begin
                sb_exp = exp_q.pop_front();
                check("result", 64'({bus_error, illegal_op, misaligned, read_data}), 64'(sb_exp));
            end
        end
    end

    // driver: one complete access, slave side answering after ack_wait REQ cycles (-1 = never)
    task automatic run_op(input logic [7:0] ops, input logic [31:0] addr, input logic [31:0] wd,
                          input int ack_wait, input logic [31:0] rd, input logic [W-1:0] exp_res,
                          input int exp_req, input bit late_ack);
        int   n;
        logic store;
        store = |(ops & (OP_SB | OP_SH | OP_SW));
        @(negedge clk);
        op_sel = ops; address = addr; write_data = wd; start = 1'b1;
        #1 check("stall_start", 64'(stall), 64'(1));
        exp_q.push_back(exp_res);
        @(negedge clk);
        n = 0;
        while (mem_if.mem_req && n < 40) begin
            check("mem_addr", 64'(mem_if.mem_addr), 64'(addr & 32'hFFFF_FFFC));
            check("mem_we", 64'(mem_if.mem_we), 64'(store));
            check("mem_wstrb", 64'(mem_if.mem_wstrb), 64'(model_wstrb(ops, addr[1:0])));
            check("mem_wdata", 64'(mem_if.mem_wdata), 64'(model_wdata(ops, wd)));
            check("stall_req", 64'(stall), 64'(1));
            mem_if.mem_ack = (n == ack_wait);
            mem_if.mem_rdata = rd;
            n++;
            @(negedge clk);
            mem_if.mem_ack = 1'b0;
        end
        start = 1'b0; op_sel = '0;
        check("req_cycles", 64'(n), 64'(exp_req));
        check("done", 64'(done), 64'(1));
        check("stall_done", 64'(stall), 64'(0));
        check("bus_idle_in_done", 64'({mem_if.mem_req, mem_if.mem_we, mem_if.mem_wstrb}), 64'(0));
        if (late_ack) mem_if.mem_ack = 1'b1;
        @(negedge clk);
        mem_if.mem_ack = 1'b0;
        check("done_clear", 64'(done), 64'(0));
        check("state_idle", 64'(dbg_state), 64'(IDLE));
        check("flags_clear", 64'({bus_error, illegal_op, misaligned, read_data}), 64'(0));
        check("req_after", 64'(mem_if.mem_req), 64'(0));
    endtask

    initial begin
        logic [7:0]  ops_tbl[8];
        logic [7:0]  op;
        logic [31:0] a, wd, rd;
        int          aw;
        ops_tbl = '{OP_SB, OP_SH, OP_SW, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
        mem_if.mem_ack = 1'b0;
        mem_if.mem_rdata = '0;

        repeat (2) @(negedge clk);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        check("rst_bus", 64'({mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wstrb}), 64'(0));
        check("rst_wdata", 64'(mem_if.mem_wdata), 64'(0));
        check("rst_outs", 64'({done, misaligned, illegal_op, bus_error, stall}), 64'(0));
        check("rst_read_data", 64'(read_data), 64'(0));
        rst = 1'b0;

        run_op(OP_LW,  32'h10, 32'h0, 0, 32'hDEADBEEF, pack(0, 0, 0, 32'hDEADBEEF), 1, 0);
        run_op(OP_LB,  32'h13, 32'h0, 0, 32'h80FF0000, pack(0, 0, 0, 32'hFFFFFF80), 1, 0);
        run_op(OP_LBU, 32'h13, 32'h0, 0, 32'h80FF0000, pack(0, 0, 0, 32'h00000080), 1, 0);
        run_op(OP_SH,  32'h22, 32'h0000ABCD, 1, 32'h12345678, pack(0, 0, 0, 32'h0), 2, 0);
        run_op(OP_SB,  32'h41, 32'h1234565A, 0, 32'h0, pack(0, 0, 0, 32'h0), 1, 0);
        run_op(OP_LH,  32'h52, 32'h0, 2, 32'h92345678, pack(0, 0, 0, 32'hFFFF9234), 3, 0);
        run_op(OP_LHU, 32'h52, 32'h0, 0, 32'h92345678, pack(0, 0, 0, 32'h00009234), 1, 0);
        run_op(OP_SW,  32'h06, 32'hCAFEF00D, 0, 32'h0, pack(0, 0, 1, 32'h0), 0, 0);
        run_op(OP_LH,  32'h01, 32'h0, 0, 32'h0, pack(0, 0, 1, 32'h0), 0, 0);
        run_op(OP_LW | OP_SB, 32'h10, 32'h0, 0, 32'h0, pack(0, 1, 0, 32'h0), 0, 0);
        run_op(8'h00,  32'h10, 32'h0, 0, 32'h0, pack(0, 1, 0, 32'h0), 0, 0);
        run_op(OP_LW,  32'h100, 32'h0, -1, 32'hFFFFFFFF, pack(1, 0, 0, 32'h0), 4, 1);

        // reset in the second REQ cycle aborts the access
        @(negedge clk);
        op_sel = OP_LW; address = 32'h40; start = 1'b1;
        @(negedge clk);
        check("abort_req1", 64'(mem_if.mem_req), 64'(1));
        @(negedge clk);
        check("abort_req2", 64'(mem_if.mem_req), 64'(1));
        rst = 1'b1; start = 1'b0; op_sel = '0;
        @(negedge clk);
        check("abort_req", 64'(mem_if.mem_req), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_state", 64'(dbg_state), 64'(IDLE));
        rst = 1'b0;
        run_op(OP_LW, 32'h44, 32'h0, 0, 32'h0BADF00D, pack(0, 0, 0, 32'h0BADF00D), 1, 0);

        for (int i = 0; i < 24; i++) begin
            op = ops_tbl[$urandom_range(0, 7)];
            a  = $urandom & 32'hFFFF_FFF0;
            if (op == OP_SB || op == OP_LB || op == OP_LBU)
                a[1:0] = 2'($urandom_range(0, 3));
            else if (op == OP_SH || op == OP_LH || op == OP_LHU)
                a[1] = 1'($urandom_range(0, 1));
            wd = $urandom;
            rd = $urandom;
            aw = $urandom_range(0, 2);
            run_op(op, a, wd, aw, rd, pack(0, 0, 0, model_load(op, a[1:0], rd)), aw + 1, 0);
        end

        check("sb_drain", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle memory access stage between the ALU address output and the writeback mux' load input.
- Replaces the zero-latency data-memory path.
- Accepts one load/store per request and drives a word-aligned memory bus with byte strobes and a valid/ack handshake.
- Returns sign/zero-extended load data and raises a stall so the PC and register file hold until the access completes.

Parameters:
- TIMEOUT_CYCLES, 16: max REQ cycles without mem_ack before bus error; legal range 1..255.
- ADDR_W, 32: address width.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request valid; sampled only in IDLE.
- sb, sh, sw, lb, lh, lw, lbu, lhu  input  1 each  one-hot op select from control unit.
- address  input  ADDR_W  byte address (ALU result).
- write_data  input  32  store data (rs2 value).
- stall  output  1  hold PC/regfile write.
- done  output  1  one-cycle completion pulse.
- read_data  output  32  extended load result; valid while done=1.
- misaligned  output  1  valid with done.
- illegal_op  output  1  valid with done.
- bus_error  output  1  valid with done.
- mem_req  output  1  bus request.
- mem_we  output  1  1 = write.
- mem_addr  output  ADDR_W  word address; bits [1:0] = 0.
- mem_wdata  output  32  lane-replicated store data.
- mem_wstrb  output  4  byte strobes; 0 on reads.
- mem_ack  input  1  access complete; read data valid the same cycle.
- mem_rdata  input  32  read word.

Behaviour:
- Reset: state IDLE. All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, done, read_data, misaligned, illegal_op, bus_error, timeout counter.
- Reset mid-operation aborts; mem_req is 0 from the next edge. A late mem_ack is ignored.
- FSM states: IDLE, REQ, DONE.
- IDLE, start=0: remain.
- IDLE, start=1, number of asserted op bits != 1: go to DONE with illegal_op=1; no bus request.
- IDLE, start=1, misaligned access: go to DONE with misaligned=1; no bus request.
  - lh/lhu/sh: misaligned when address[0]=1.
  - lw/sw: misaligned when address[1:0]!=0.
- IDLE, start=1, legal and aligned: go to REQ.
  - Register op, address[1:0], mem_addr={address[31:2],2'b00}, mem_wdata, mem_wstrb.
  - Set mem_req=1; set mem_we=1 for stores.
- REQ, mem_ack=1: go to DONE; capture the extracted load data (loads only).
- REQ, mem_ack=0: counter increments. When counter reaches TIMEOUT_CYCLES-1 with no ack: go to DONE with bus_error=1 and read_data=0.
- REQ: mem_req and all bus outputs stay stable until ack or timeout.
- DONE: done=1 for exactly one cycle, then IDLE. A new start is accepted in the following IDLE cycle.
- read_data is 0 for stores and errors.
- mem_req, mem_we, mem_wstrb and mem_wdata are 0 outside REQ.
- Error flags return to 0 in IDLE.
- stall (combinational) = (state==IDLE & start) | state==REQ. stall=0 in DONE so the PC advances and writeback uses read_data that cycle.
- Latency:
  - Start at cycle T gives mem_req at T+1.
  - Ack at cycle A gives done at A+1.
  - Minimum load/store latency is 2 cycles (ack in first REQ cycle).
  - Error detected in IDLE gives done at T+1.
- Store lanes (off = address[1:0]):
  - sb: wdata = byte replicated ×4; wstrb = 4'b0001<<off.
  - sh: wdata = halfword replicated ×2; wstrb = off[1] ? 4'b1100 : 4'b0011.
  - sw: wdata = write_data; wstrb = 4'b1111.
- Load extraction:
  - lb/lbu: byte = mem_rdata[8*off +: 8].
  - lh/lhu: half = mem_rdata[16*off[1] +: 16].
  - lb/lh: sign-extend to 32 bits.
  - lbu/lhu: zero-extend to 32 bits.
  - lw: mem_rdata as is.
- start asserted outside IDLE is ignored. The control unit holds start asserted while stall=1.

Decomposition:
- Shared package holds:
  - State encoding: IDLE=2'd0, REQ=2'd1, DONE=2'd2.
  - Op-size constants: BYTE, HALF, WORD.
  - Strobe constant WSTRB_ALL=4'b1111.
- One natural combinational sub-module, lsu_lane_align: store replication/strobe generation plus load extraction and extension. It is also reusable by a future cache.
- FSM, timeout counter and request registers live in load_store_unit.

Test Plan:
- lw, address=0x0000_0010, mem_ack on the first REQ cycle, mem_rdata=0xDEADBEEF → mem_addr=0x10; done two cycles after start; read_data=0xDEADBEEF; stall high for cycles T and T+1 only.
- lb at 0x13 with mem_rdata=0x80FF_0000, then lbu at the same address → lb read_data=0xFFFF_FF80; lbu read_data=0x0000_0080.
- sh, address=0x22, write_data=0x0000_ABCD → mem_wdata=0xABCD_ABCD; mem_wstrb=4'b1100; mem_we=1; read_data=0.
- sw at 0x0000_0006 → no mem_req; done at T+1 with misaligned=1. Separately, lw with sb also asserted → done at T+1 with illegal_op=1.
- Timeout: lw with TIMEOUT_CYCLES=4 and mem_ack never asserted → mem_req high exactly 4 cycles; done with bus_error=1 and read_data=0; mem_ack asserted one cycle later is ignored.
- rst pulsed during the second REQ cycle → next cycle: mem_req=0, done=0, state IDLE. A fresh lw then completes normally.
